// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Shared image-pipeline defaults and the fetch-streamer FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int c_PIX_W      = 8;
    localparam int c_FRAME_SIZE = 98304;
    localparam int c_ADDR_W     = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pix_fetch_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : pix_fetch_streamer_if
// Description : Image-memory read port plus pixel stream (optional sof/eof
//               markers when PIX_MARKERS_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
interface pix_fetch_streamer_if
    import img_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int PIX_W  = c_PIX_W
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic [PIX_W-1:0]  ip;
    logic              pix_valid;
    logic              pix_ready;
`ifdef PIX_MARKERS_EN
    logic              sof;
    logic              eof;

    modport master (
        output mem_rd_en, mem_addr, ip, pix_valid, sof, eof,
        input  mem_data, pix_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, ip, pix_valid, sof, eof,
        output mem_data, pix_ready
    );
`else
    modport master (
        output mem_rd_en, mem_addr, ip, pix_valid,
        input  mem_data, pix_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, ip, pix_valid,
        output mem_data, pix_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pix_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pix_skid_fifo
// Description : Two-entry pixel FIFO with push, pop, flush, count and head.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_skid_fifo
    import img_pkg::*;
#(
    parameter int WIDTH = c_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Push onto a full FIFO is only legal alongside a pop, so the slot being
    // overwritten is always the one leaving.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            if (!rst_n) begin
                r_mem[0] <= '0;
                r_mem[1] <= '0;
            end
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/pix_fetch_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pix_fetch_streamer
// Description : Reads one frame from image memory and streams it out with
//               ready/valid flow control. Define PIX_MARKERS_EN for sof/eof.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_fetch_streamer
    import img_pkg::*;
#(
    parameter int FRAME_SIZE = c_FRAME_SIZE,
    parameter int ADDR_W     = c_ADDR_W,
    parameter int PIX_W      = c_PIX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    pix_fetch_streamer_if.master bus
);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(FRAME_SIZE - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_out_cnt;
    logic              r_inflight;
    logic [1:0]        w_fifo_count;
    logic [1:0]        w_outstanding;
    logic [PIX_W-1:0]  w_head;
    logic              w_valid;
    logic              w_xfer;
    logic              w_room;
    logic              w_rd;
    logic              w_start;

    assign w_valid       = (w_fifo_count != 2'd0);
    assign w_xfer        = w_valid && bus.pix_ready;
    assign w_start       = (r_state == ST_IDLE) && start && !abort;
    assign w_outstanding = w_fifo_count + {1'b0, r_inflight};
    assign w_room        = (w_outstanding < 2'd2) || ((w_outstanding == 2'd2) && w_xfer);

    pix_skid_fifo #(
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (r_inflight),
        .push_data (bus.mem_data),
        .pop       (w_xfer),
        .count     (w_fifo_count),
        .head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_rd && (r_rd_cnt == c_LAST)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_xfer && (r_out_cnt == c_LAST)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_rd = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_FETCH: begin
                busy = 1'b1;
                w_rd = w_room && !abort;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Counters saturate on the last index so addresses stay inside the frame
    // even when FRAME_SIZE equals 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            if (w_start) begin
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_rd && (r_rd_cnt != c_LAST)) begin
                    r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                end
                if (w_xfer && busy && (r_out_cnt != c_LAST)) begin
                    r_out_cnt <= r_out_cnt + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.mem_rd_en = w_rd;
    assign bus.mem_addr  = r_rd_cnt;
    assign bus.ip        = w_head;
    assign bus.pix_valid = w_valid;

`ifdef PIX_MARKERS_EN
    assign bus.sof = w_valid && (r_out_cnt == '0);
    assign bus.eof = w_valid && (r_out_cnt == c_LAST);
`endif

endmodule
`default_nettype wire

// File: tb/tb_pix_fetch_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix_fetch_streamer
// Description : Scoreboard bench: 16-pixel frame DUT plus a 1-pixel frame DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pix_fetch_streamer;

    localparam int c_FS = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic abort  = 1'b0;
    logic start1 = 1'b0;
    logic abort1 = 1'b0;
    logic busy, done, busy1, done1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   sb[$];
    int   e_pix;
    int   exp_addr, n_rd, n_xf, first_xf, last_xf, start_cyc;
    bit   stalled  = 1'b0;
    logic [7:0] held_ip;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pix_fetch_streamer_if #(.ADDR_W(4), .PIX_W(8)) bus0 ();
    pix_fetch_streamer_if #(.ADDR_W(4), .PIX_W(8)) bus1 ();

    pix_fetch_streamer #(.FRAME_SIZE(c_FS), .ADDR_W(4), .PIX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus0)
    );

    pix_fetch_streamer #(.FRAME_SIZE(1), .ADDR_W(4), .PIX_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .abort (abort1),
        .busy  (busy1),
        .done  (done1),
        .bus   (bus1)
    );

    // Memory models: one-cycle read latency, garbage when not read.
    always @(posedge clk) bus0.mem_data <= bus0.mem_rd_en ? 8'(bus0.mem_addr) : 8'hEE;
    always @(posedge clk) bus1.mem_data <= bus1.mem_rd_en ? (8'h5A ^ 8'(bus1.mem_addr)) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.mem_rd_en) begin
                chk("rd_addr", 32'(bus0.mem_addr), exp_addr);
                exp_addr++;
                n_rd++;
            end
            if (stalled) begin
                chk("stall_valid", 32'(bus0.pix_valid), 1);
                chk("stall_hold", 32'(bus0.ip), 32'(held_ip));
            end
            if (bus0.pix_valid && bus0.pix_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e_pix = sb.pop_front();
                    chk("pix", 32'(bus0.ip), e_pix);
                end
                n_xf++;
                if (first_xf < 0) first_xf = cyc;
                last_xf = cyc;
            end
            if (busy) chk("outstanding_le2", 32'((n_rd - n_xf) <= 2), 1);
            stalled = bus0.pix_valid && !bus0.pix_ready;
            held_ip = bus0.ip;
        end
        if (!rst_n || abort) begin
            sb.delete();
            n_rd    = 0;
            n_xf    = 0;
            stalled = 1'b0;
        end
    end

    task automatic start_frame;
        for (int i = 0; i < c_FS; i++) sb.push_back(i);
        exp_addr  = 0;
        n_rd      = 0;
        n_xf      = 0;
        first_xf  = -1;
        start_cyc = cyc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // mode 0: ready high; 1: ready toggling with start pulsed mid-frame; 2: ready low 10 cycles
    task automatic run_until_done(input int mode, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            case (mode)
                0: bus0.pix_ready = 1'b1;
                1: bus0.pix_ready = (i % 2 == 0);
                default: begin
                    if (i == 10) begin
                        chk("stall_reads", n_rd, 2);
                        chk("stall_next_addr", exp_addr, 2);
                    end
                    bus0.pix_ready = (i >= 10);
                end
            endcase
            start = (mode == 1) && (i >= 3) && (i < 8);
            @(negedge clk);
            if (done) seen = 1'b1;
            else tick();
        end
        chk("done_seen", 32'(seen), 1);
        chk("done_lat", cyc - last_xf, 1);
        chk("sb_empty", sb.size(), 0);
        chk("xfer_count", n_xf, c_FS);
        if (mode == 0) begin
            chk("first_latency", first_xf - start_cyc, 3);
            chk("no_bubbles", last_xf - first_xf, c_FS - 1);
        end
        tick();
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        tick();
    endtask

    task automatic chk_reset;
        chk("rst_rd_en", 32'(bus0.mem_rd_en), 0);
        chk("rst_addr", 32'(bus0.mem_addr), 0);
        chk("rst_ip", 32'(bus0.ip), 0);
        chk("rst_valid", 32'(bus0.pix_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
    endtask

    task automatic chk_idle(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(tag, 32'({busy, bus0.mem_rd_en, done}), 0);
            tick();
        end
    endtask

    initial begin
        bus0.pix_ready = 1'b0;
        bus1.pix_ready = 1'b1;
        // Reset with start held high on both DUTs.
        start  = 1'b1;
        start1 = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_reset();
        tick();
        rst_n  = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        chk_idle("idle_after_reset");

        start_frame();
        run_until_done(0, 60);

        start_frame();
        run_until_done(1, 100);

        bus0.pix_ready = 1'b0;
        start_frame();
        run_until_done(2, 100);

        // Abort while pixel 7 is presented.
        start_frame();
        bus0.pix_ready = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 40 && !hit; i++) begin
                if (bus0.pix_valid && bus0.ip == 8'd7) hit = 1'b1;
                else tick();
            end
            chk("abort_reached_px7", 32'(hit), 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(bus0.pix_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        tick();
        chk_idle("abort_no_done");
        start_frame();
        run_until_done(0, 60);

        // Reset mid-frame with start held high.
        start_frame();
        repeat (6) tick();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk_reset();
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        chk_idle("idle_after_midreset");
        start_frame();
        run_until_done(0, 60);

        // Single-pixel frame on the second DUT.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        @(negedge clk);
        chk("fs1_rd_en", 32'(bus1.mem_rd_en), 1);
        chk("fs1_addr", 32'(bus1.mem_addr), 0);
        chk("fs1_busy", 32'(busy1), 1);
        tick();
        @(negedge clk);
        chk("fs1_single_read", 32'(bus1.mem_rd_en), 0);
        chk("fs1_drain_busy", 32'(busy1), 1);
        tick();
        @(negedge clk);
        chk("fs1_valid", 32'(bus1.pix_valid), 1);
        chk("fs1_ip", 32'(bus1.ip), 32'h5A);
        chk("fs1_early_done", 32'(done1), 0);
`ifdef PIX_MARKERS_EN
        chk("fs1_sof", 32'(bus1.sof), 1);
        chk("fs1_eof", 32'(bus1.eof), 1);
`endif
        tick();
        @(negedge clk);
        chk("fs1_done", 32'(done1), 1);
        chk("fs1_valid_after", 32'(bus1.pix_valid), 0);
        tick();
        @(negedge clk);
        chk("fs1_done_pulse", 32'(done1), 0);
        chk("fs1_idle", 32'(busy1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
